// File: rtl/piso_tx_arbiter_pkg.sv
// rtl/piso_tx_arbiter_pkg.sv - shared FSM state type and requester indices for the PISO transmit arbiter
package piso_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/piso_shifter.sv
// rtl/piso_shifter.sv - parallel-load, right-shifting register exposing its LSB
module piso_shifter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift_en,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_q;

    // Load wins over shift so a new word is never corrupted by a stale enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift_en) begin
            r_q <= {1'b0, r_q[WIDTH-1:1]};
        end
    end

    assign o_lsb = r_q[0];

endmodule

// File: rtl/piso_tx_arbiter.sv
// rtl/piso_tx_arbiter.sv - two-way round-robin arbiter and sequencer for a shared serial transmitter
module piso_tx_arbiter
    import piso_tx_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    input  logic             pause,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             grant_id,
    output logic             busy
);

    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_LAST_I);

    state_t          r_state;
    logic            r_rr_ptr;
    logic [CW-1:0]   r_bit_cnt;
    logic [GCW-1:0]  r_gap_cnt;

    logic             w_sel;
    logic             w_xfer;
    logic             w_shift;
    logic             w_lsb;
    logic [WIDTH-1:0] w_sel_data;

    // r_rr_ptr names the requester that wins the next tie.
    always_comb begin
        w_sel = REQ0;
        if (req_valid == 2'b11) begin
            w_sel = r_rr_ptr;
        end else if (req_valid[1]) begin
            w_sel = REQ1;
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == ST_IDLE && req_valid[w_sel]) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    assign w_xfer     = |(req_valid & req_ready);
    assign w_shift    = (r_state == ST_SHIFT) && !pause;
    assign w_sel_data = (w_sel == REQ1) ? req_data1 : req_data0;

    piso_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_xfer),
        .i_data     (w_sel_data),
        .i_shift_en (w_shift),
        .o_lsb      (w_lsb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= REQ0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            grant_id    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        grant_id  <= w_sel;
                        r_rr_ptr  <= ~w_sel;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                        busy      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // A paused cycle leaves ser_out, shifter and counter untouched.
                    if (!pause) begin
                        ser_out     <= w_lsb;
                        ser_valid   <= 1'b1;
                        frame_start <= (r_bit_cnt == '0);
                        frame_end   <= (r_bit_cnt == BIT_LAST);
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_gap_cnt <= '0;
                            if (GAP > 0) begin
                                r_state <= ST_GAP;
                            end else begin
                                r_state <= ST_IDLE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// tb/tb_piso_tx_arbiter.sv - self-checking bench for piso_tx_arbiter
module tb_piso_tx_arbiter;

    localparam int WIDTH = 4;
    localparam int GAP   = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [WIDTH-1:0] req_data0 = '0;
    logic [WIDTH-1:0] req_data1 = '0;
    logic             pause = 1'b0;
    logic [1:0]       req_ready;
    logic             ser_out, ser_valid, frame_start, frame_end, grant_id, busy;

    logic [1:0]       g0_valid = '0;
    logic [WIDTH-1:0] g0_d0 = '0;
    logic [WIDTH-1:0] g0_d1 = '0;
    logic             g0_pause = 1'b0;
    logic [1:0]       g0_ready;
    logic             g0_so, g0_sv, g0_fs, g0_fe, g0_grant, g0_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piso_tx_arbiter #(.WIDTH(WIDTH), .GAP(GAP)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0),
        .req_data1(req_data1), .req_ready(req_ready), .pause(pause),
        .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
        .frame_end(frame_end), .grant_id(grant_id), .busy(busy)
    );

    piso_tx_arbiter #(.WIDTH(WIDTH), .GAP(0)) u_dut_g0 (
        .clk(clk), .rst(rst), .req_valid(g0_valid), .req_data0(g0_d0),
        .req_data1(g0_d1), .req_ready(g0_ready), .pause(g0_pause),
        .ser_out(g0_so), .ser_valid(g0_sv), .frame_start(g0_fs),
        .frame_end(g0_fe), .grant_id(g0_grant), .busy(g0_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready must never be offered to an idle requester, nor to both at once.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            check("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
            check("ready_onehot", 32'(req_ready == 2'b11), 32'd0);
        end
    end

    // ---------------- behavioural reference model ----------------
    int   m_phase;     // 0 idle, 1 sending, 2 gap
    int   m_rr;
    int   m_gap_left;
    int   m_q[$];
    logic e_so, e_sv, e_fs, e_fe, e_busy, e_grant;

    task automatic m_reset();
        m_phase = 0; m_rr = 0; m_gap_left = 0; m_q.delete();
        e_so = 0; e_sv = 0; e_fs = 0; e_fe = 0; e_busy = 0; e_grant = 0;
    endtask

    function automatic logic [1:0] m_ready(input logic [1:0] v);
        int sel;
        if (m_phase != 0 || v == 2'b00) return 2'b00;
        if (v == 2'b11) sel = m_rr;
        else sel = v[1] ? 1 : 0;
        return (sel == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic m_step(input logic [1:0] v, input logic [WIDTH-1:0] d0,
                          input logic [WIDTH-1:0] d1, input logic p);
        logic [1:0]       rdy;
        logic [WIDTH-1:0] w;
        int               sel;
        int               b;
        rdy = m_ready(v);
        e_sv = 0; e_fs = 0; e_fe = 0;
        if (m_phase == 0) begin
            if (rdy != 2'b00) begin
                sel = rdy[1] ? 1 : 0;
                w = (sel == 1) ? d1 : d0;
                m_q.delete();
                for (int k = 0; k < WIDTH; k++) m_q.push_back(int'(w[k]));
                e_grant = (sel == 1);
                m_rr = 1 - sel;
                m_phase = 1;
                e_busy = 1;
            end
        end else if (m_phase == 1) begin
            if (!p) begin
                e_fs = (m_q.size() == WIDTH);
                b = m_q.pop_front();
                e_so = (b != 0);
                e_sv = 1;
                e_fe = (m_q.size() == 0);
                if (m_q.size() == 0) begin
                    m_phase = 2; m_gap_left = GAP;
                end
            end
        end else begin
            m_gap_left--;
            if (m_gap_left == 0) begin
                m_phase = 0; e_busy = 0;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             rst_first;
        logic [1:0]       valid;
        logic [WIDTH-1:0] d0, d1;
        logic             pause;
        logic [1:0]       ready;
        logic [5:0]       outs;    // {so, sv, fs, fe, busy, grant}
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic r, input logic [1:0] v, input logic [WIDTH-1:0] d0,
                        input logic [WIDTH-1:0] d1, input logic [1:0] rdy, input logic [5:0] o);
        vec_t x;
        x.rst_first = r; x.valid = v; x.d0 = d0; x.d1 = d1; x.pause = 1'b0;
        x.ready = rdy; x.outs = o;
        vecs.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = '0; pause = 1'b0; g0_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        m_reset();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int starts[$];
    int ends_seen, sv_lows, lows;
    logic [WIDTH-1:0] bits;
    int nb;
    logic saw_busy;

    initial begin
        m_reset();
        #1;
        check("reset_outs", 32'({ser_out, ser_valid, frame_start, frame_end, busy, grant_id}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // single word from requester 0, then a tie sequence from reset
        addv(1, 2'b01, 4'b1011, 4'h0, 2'b01, 6'b000010);
        addv(0, 2'b00, 4'b1011, 4'h0, 2'b00, 6'b111010);
        addv(0, 2'b00, 4'b1011, 4'h0, 2'b00, 6'b110010);
        addv(0, 2'b00, 4'b1011, 4'h0, 2'b00, 6'b010010);
        addv(0, 2'b00, 4'b1011, 4'h0, 2'b00, 6'b110110);
        addv(0, 2'b00, 4'b1011, 4'h0, 2'b00, 6'b100000);
        addv(0, 2'b00, 4'b1011, 4'h0, 2'b00, 6'b100000);
        addv(1, 2'b11, 4'hA, 4'h5, 2'b01, 6'b000010);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b00, 6'b011010);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b00, 6'b110010);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b00, 6'b010010);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b00, 6'b110110);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b00, 6'b100000);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b10, 6'b100011);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b00, 6'b111011);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b00, 6'b010011);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b00, 6'b110011);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b00, 6'b010111);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b00, 6'b000001);
        addv(0, 2'b11, 4'hA, 4'h5, 2'b01, 6'b000010);

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            @(negedge clk);
            req_valid = vecs[i].valid; req_data0 = vecs[i].d0;
            req_data1 = vecs[i].d1; pause = vecs[i].pause;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
            cyc();
            check($sformatf("vec%0d_outs", i),
                  32'({ser_out, ser_valid, frame_start, frame_end, busy, grant_id}),
                  32'(vecs[i].outs));
        end

        // pause for two cycles after bit 1 of 4'hC
        do_reset();
        @(negedge clk); req_valid = 2'b01; req_data0 = 4'hC;
        cyc();
        ends_seen = 0; sv_lows = 0; nb = 0; bits = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); req_valid = 2'b00; pause = (k == 3 || k == 4);
            cyc();
            if (ser_valid && nb < WIDTH) begin bits[nb] = ser_out; nb++; end
            if (frame_end) begin
                ends_seen++;
                check("pause_end_cycle", 32'(k), 32'd6);
            end
            if (k <= 6 && !ser_valid) sv_lows++;
        end
        pause = 1'b0;
        check("pause_bits", 32'(bits), 32'hC);
        check("pause_bitcount", 32'(nb), 32'(WIDTH));
        check("pause_end_once", 32'(ends_seen), 32'd1);
        check("pause_gaps", 32'(sv_lows), 32'd2);

        // reset in the middle of a requester-0 frame
        do_reset();
        @(negedge clk); req_valid = 2'b01; req_data0 = 4'h6;
        cyc();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); req_valid = 2'b00;
            cyc();
        end
        @(negedge clk); rst = 1'b0;
        #1;
        check("midrst_outs", 32'({ser_out, ser_valid, frame_start, frame_end, busy, grant_id}), 32'd0);
        @(negedge clk); rst = 1'b1;
        ends_seen = 0; sv_lows = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (frame_end) ends_seen++;
            if (ser_valid || busy) sv_lows++;
        end
        check("midrst_no_end", 32'(ends_seen), 32'd0);
        check("midrst_idle", 32'(sv_lows), 32'd0);
        @(negedge clk); req_valid = 2'b11; req_data0 = 4'h1; req_data1 = 4'h2;
        #1;
        check("midrst_tie_ready", 32'(req_ready), 32'd1);
        cyc();
        check("midrst_tie_grant", 32'(grant_id), 32'd0);

        // requester 1 raises then withdraws valid while requester 0 owns the shifter
        do_reset();
        @(negedge clk); req_valid = 2'b01; req_data0 = 4'h3;
        cyc();
        nb = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk); req_valid = (k == 2 || k == 3) ? 2'b10 : 2'b00;
            #1;
            check($sformatf("withdraw_ready%0d", k), 32'(req_ready), 32'd0);
            cyc();
            if (ser_valid) nb++;
        end
        check("withdraw_bits", 32'(nb), 32'(WIDTH));
        check("withdraw_idle", 32'({busy, grant_id}), 32'd0);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]       v;
            logic [WIDTH-1:0] a, b;
            logic             p;
            v = 2'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
            p = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            req_valid = v; req_data0 = a; req_data1 = b; pause = p;
            #1;
            check("rand_ready", 32'(req_ready), 32'(m_ready(v)));
            m_step(v, a, b, p);
            cyc();
            check("rand_outs",
                  32'({ser_out, ser_valid, frame_start, frame_end, busy, grant_id}),
                  32'({e_so, e_sv, e_fs, e_fe, e_busy, e_grant}));
        end

        // GAP=0 instance: requester 1 held valid continuously
        do_reset();
        @(negedge clk); g0_valid = 2'b10; g0_d1 = 4'h9;
        starts.delete(); lows = 0; saw_busy = 1'b0;
        for (int k = 0; k < 32; k++) begin
            cyc();
            if (g0_fs) starts.push_back(k);
            if (g0_busy) saw_busy = 1'b1;
            if (starts.size() > 0 && !g0_busy) lows++;
        end
        g0_valid = 2'b00;
        check("g0_busy_seen", 32'(saw_busy), 32'd1);
        check("g0_frames", 32'(starts.size() >= 5), 32'd1);
        for (int i = 1; i < starts.size(); i++)
            check($sformatf("g0_period%0d", i), 32'(starts[i] - starts[i-1]), 32'(WIDTH + 1));
        check("g0_busy_lows", 32'(lows), 32'((starts.size() > 0) ? (31 - starts[0]) / (WIDTH + 1) : 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Sequencer and two-way round-robin arbiter for a shared parallel-in/serial-out shift register in the serial-transmit path of the S3 lab designs. Two requesters each offer a WIDTH-bit word through a valid/ready handshake. The block grants one requester, loads its word into the shifter, and emits the word LSB-first, one bit per cycle, with frame strobes. It then inserts a configurable idle gap before the next grant.

## Interface
- WIDTH, 4: word width in bits; must be ≥ 2.
- GAP, 1: idle cycles between frames; 0 is legal.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  2  per-requester word-available flag.
- req_data0  input  WIDTH  word from requester 0.
- req_data1  input  WIDTH  word from requester 1.
- req_ready  output  2  per-requester accept; at most one bit high.
- pause  input  1  freezes shifting while high.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_start  output  1  high with bit 0 of a frame.
- frame_end  output  1  high with bit WIDTH-1 of a frame.
- grant_id  output  1  requester that owns the current frame.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- FSM states are IDLE, SHIFT and GAP.
- **IDLE**
  - The block selects a requester. If only one requester is valid, it is selected. If both are valid, the one not granted most recently is selected.
  - `req_ready[sel]` is driven combinationally in IDLE when `req_valid[sel]` is high.
  - A transfer happens when valid and ready are both high. On a transfer, the word is loaded into the shifter, `grant_id` takes `sel`, the round-robin pointer moves to the other requester, the bit counter clears to 0, and the state moves to SHIFT.
- **SHIFT**
  - Each non-paused cycle, the block drives `ser_out` = shifter[0] and `ser_valid` = 1, shifts the register right with 0 fill, and increments the counter.
  - `frame_start` is high when count == 0. `frame_end` is high when count == WIDTH-1.
  - After the last bit, the state moves to GAP if GAP > 0, otherwise to IDLE.
- **Pause in SHIFT**
  - While `pause` is high, the shifter and counter hold and `ser_valid`, `frame_start` and `frame_end` are 0.
  - `ser_out` holds its last value.
  - A pause does not abort the frame.
- **GAP**
  - The state lasts exactly GAP cycles, counted by its own counter, then returns to IDLE.
  - `pause` has no effect in GAP.
- `req_ready` is 0 in SHIFT and GAP. Requesters may hold or drop `req_valid` at any time; the data word is sampled only at the transfer edge.
- Counter width is $clog2(WIDTH)+1 bits. The gap counter is $clog2(GAP+1) bits, with a minimum of 1.
- **Reset** (asynchronous, active-low) forces:
  - state to IDLE and the round-robin pointer to 0, so requester 0 wins the first tie;
  - shifter and both counters to 0;
  - `ser_out`, `ser_valid`, `frame_start`, `frame_end`, `grant_id` and `busy` to 0.
- **Reset mid-frame** aborts the frame with no `frame_end`. Any remaining bits are discarded and not retransmitted.

## Timing
- `ser_out`, `ser_valid`, `frame_start`, `frame_end`, `grant_id` and `busy` are registered.
- Transfer at edge N gives bit 0 on the outputs after edge N+1. Bit k appears after edge N+1+k when no pause occurs.
- `busy` rises after the transfer edge and falls after the last GAP cycle, or after the last bit when GAP = 0.
- With no pauses, frames start every WIDTH + GAP + 1 cycles. The +1 is the IDLE accept cycle.
- Each pause cycle extends the frame by one cycle.
- When `pause` and the last bit coincide, the last bit is withheld until `pause` drops.

## Structure
- A shared package holds:
  - the state enum {IDLE, SHIFT, GAP};
  - requester-index constants REQ0 = 0 and REQ1 = 1.
- Sub-module `piso_shifter`: a WIDTH-bit register with load, shift_en and LSB output, asynchronous active-low reset to 0.
- The arbiter, FSM and counters live in the top module.

## Test plan
- **Single word, requester 0 only:** WIDTH=4, GAP=1, `req_valid`=01, data0=4'b1011.
  - `req_ready[0]` is high for one cycle.
  - Over 4 cycles `ser_out` = 1,1,0,1 with `ser_valid` high.
  - `frame_start` is high on the 1st bit and `frame_end` on the 4th; `grant_id` = 0.
  - One GAP cycle follows, then `busy` = 0.
- **Tie:** both valid from reset, data0=4'hA, data1=4'h5.
  - Grants alternate 0, 1, 0, 1.
  - Serial streams are 0,1,0,1 then 1,0,1,0.
- **Pause:** `pause` high for 2 cycles after bit 1 of data 4'hC.
  - `ser_valid` is 0 for 2 cycles; bits read 0,0,1,1 in order.
  - The frame is 2 cycles longer; `frame_end` appears only once.
- **Reset mid-frame:** `rst` low after bit 2.
  - All outputs go to 0 immediately.
  - No `frame_end` appears; the state returns to IDLE.
  - The next tie grants requester 0.
- **GAP=0:** requester 1 valid continuously.
  - A new frame starts every 5 cycles.
  - `busy` drops for exactly the one IDLE cycle.
- **Valid withdrawn:** requester 1 asserts valid, and it is dropped before a grant occurs (requester 0 busy).
  - No transfer occurs for requester 1.
  - `req_ready[1]` is never high while `req_valid[1]` is 0.
